btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The block SHALL have a single clock, clk; reset SHALL be asynchronous and active-high, named reset.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000, SHALL be the consecutive disagreeing cycles needed to accept a level change (10 ms at 25 MHz); legal range is 1 to 2^CNT_W-1.
REQ-003 Parameter CNT_W, default 18, SHALL be the width of each per-button debounce counter.
REQ-004 clk  input  1  system clock, rising-edge active.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 btn_raw  input  4  raw pushbuttons {btnL, btnC, btnR, btnU}, asynchronous to clk.
REQ-007 clr  input  1  one-cycle clear strobe from the CPU I/O port.
REQ-008 clr_mask  input  4  per-bit sticky-clear select, qualified by clr.
REQ-009 btn_level  output  4  debounced button level, feeds the dmem_io btn port.
REQ-010 btn_pulse  output  4  one-cycle press event per button.
REQ-011 btn_sticky  output  4  latched press flags awaiting CPU acknowledge.
REQ-012 any_pending  output  1  OR-reduction of btn_sticky.

Function
REQ-013 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each button SHALL hold a stable state (drives btn_level) and a CNT_W-bit counter.
REQ-015 Synchronized value equal to stable state: counter SHALL load 0 that edge.
REQ-016 Synchronized value differing and counter < DEBOUNCE_CYCLES-1: counter SHALL increment.
REQ-017 Synchronized value differing and counter == DEBOUNCE_CYCLES-1: stable state SHALL take the synchronized value and counter SHALL load 0.
REQ-018 Latency: with the first edge sampling a new raw value as edge 1, btn_level SHALL change on edge DEBOUNCE_CYCLES+2, given the raw value is held throughout.
REQ-019 Any bounce that returns the synchronized value to the stable state before acceptance SHALL zero the counter; the full DEBOUNCE_CYCLES restarts.
REQ-020 btn_pulse[i] SHALL be registered and high for exactly one cycle: the first cycle btn_level[i] is 1 after a 0-to-1 transition; releases SHALL produce no pulse.
REQ-021 btn_sticky[i] SHALL set on the edge that raises btn_pulse[i], i.e. it becomes 1 in the same cycle btn_pulse[i] is high.
REQ-022 clr=1 SHALL clear every btn_sticky bit whose clr_mask bit is 1 on that edge; clr_mask is ignored when clr=0.
REQ-023 A set and a clear of the same sticky bit on the same edge SHALL leave the bit at 1 (set wins).
REQ-024 Buttons SHALL be fully independent; simultaneous presses SHALL produce simultaneous pulses and sticky bits.
REQ-025 any_pending SHALL be combinational from btn_sticky, with no added latency.
REQ-026 The counter SHALL never wrap; it is bounded by REQ-017.

Reset
REQ-027 While reset is high, all synchronizer flops, stable states, counters, btn_level, btn_pulse, btn_sticky and any_pending SHALL be 0, independent of clk and btn_raw.
REQ-028 After reset deasserts with a button already held, the press SHALL be treated as new: full REQ-018 latency, then one pulse and a sticky set.
REQ-029 Reset asserted mid-count SHALL discard the partial count.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 reset=1, btn_raw=4'hF, toggle clk -> all outputs 0 throughout.
REQ-031 Clean press: btn_raw=4'b0010 held from edge 1 -> btn_level=4'b0010 at edge 6; btn_pulse=4'b0010 for one cycle only; btn_sticky=4'b0010; any_pending=1.
REQ-032 Glitch: btn_raw[0]=1 for 3 cycles then 0 -> btn_level, btn_pulse and btn_sticky stay 0; counter returns to 0.
REQ-033 Clear: with sticky=4'b0011, clr=1, clr_mask=4'b0010 -> sticky=4'b0001 next cycle; clr coincident with a new bit-1 pulse -> bit 1 stays 1.
REQ-034 Release after a held press -> btn_level falls at edge 6 of the release, with no pulse and btn_sticky unchanged.
REQ-035 Reset mid-count: raw=4'b1000 for 3 edges, pulse reset, keep raw held -> outputs 0, then btn_level[3]=1 exactly 6 edges after reset release.

Source files
------------

// File: rtl/btn_conditioner.sv
// Four-button input conditioner: 2-flop synchronizers, per-button debounce,
// one-cycle press pulses and CPU-acknowledged sticky press flags.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  input  logic       clr,
  input  logic [3:0] clr_mask,
  output logic [3:0] btn_level,
  output logic [3:0] btn_pulse,
  output logic [3:0] btn_sticky,
  output logic       any_pending
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0] sync1_q, sync2_q;
  logic [3:0] level_q, level_d;
  logic [3:0] pulse_q, pulse_d;
  logic [3:0] sticky_q, sticky_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    // Any cycle agreeing with the stable state zeroes the count, so a bounce
    // restarts the full debounce window.
    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q[gi] != stable_q) begin
        if (cnt_q == CNT_MAX) begin
          stable_d = sync2_q[gi];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign level_q[gi] = stable_q;
    assign level_d[gi] = stable_d;
  end

  // Set is OR-ed in after the clear so a coincident press wins.
  always_comb begin
    pulse_d  = level_d & ~level_q;
    sticky_d = (sticky_q & ~(clr ? clr_mask : 4'b0000)) | pulse_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_q  <= '0;
      sticky_q <= '0;
    end else begin
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_pulse   = pulse_q;
  assign btn_sticky  = sticky_q;
  assign any_pending = |sticky_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomized and directed checks of btn_conditioner against a run-length
// behavioural model of the debounce, pulse and sticky rules.
module tb_btn_conditioner;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic       clr;
  logic [3:0] clr_mask;
  logic [3:0] btn_level, btn_pulse, btn_sticky;
  logic       any_pending;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .clr(clr), .clr_mask(clr_mask),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .btn_sticky(btn_sticky),
    .any_pending(any_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Model state: two-stage sample delay, accepted level, run length of
  // consecutive disagreeing samples, and the pulse/sticky flags.
  logic [3:0] m_s1, m_s2, m_level, m_pulse, m_sticky;
  int         m_run [4];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_pulse = '0; m_sticky = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [3:0] seen, nl;
    if (reset) begin
      model_clear();
      return;
    end
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = btn_raw;
    nl   = m_level;
    for (int i = 0; i < 4; i++) begin
      if (seen[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          nl[i]    = seen[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_pulse  = nl & ~m_level;
    m_sticky = (m_sticky & ~(clr ? clr_mask : 4'b0000)) | m_pulse;
    m_level  = nl;
  endtask

  task automatic compare_all();
    check_eq("level",   {28'b0, btn_level},  {28'b0, m_level});
    check_eq("pulse",   {28'b0, btn_pulse},  {28'b0, m_pulse});
    check_eq("sticky",  {28'b0, btn_sticky}, {28'b0, m_sticky});
    check_eq("pending", {31'b0, any_pending}, {31'b0, |m_sticky});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_clear();
    compare_all();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Ticks until btn_level[bit] equals val; returns the edge count (0 on timeout).
  task automatic edges_until(input int bit_i, input logic val, output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (btn_level[bit_i] == val) begin
        n = k;
        break;
      end
    end
  endtask

  int n;

  initial begin
    reset = 1'b1; btn_raw = 4'hF; clr = 1'b0; clr_mask = 4'h0;
    model_clear();
    #1;
    compare_all();
    for (int k = 0; k < 4; k++) tick();
    check_eq("rst_hold_all", {25'b0, btn_level, btn_pulse[2:0]} | {28'b0, btn_sticky}, 32'h0);
    reset = 1'b0; btn_raw = 4'h0;
    for (int k = 0; k < 4; k++) tick();

    // Clean simultaneous press of buttons 0 and 1.
    btn_raw = 4'b0011;
    for (int k = 1; k <= 5; k++) tick();
    check_eq("press_e5_level", {28'b0, btn_level}, 32'h0);
    tick();
    check_eq("press_e6_level", {28'b0, btn_level}, 32'h3);
    check_eq("press_e6_pulse", {28'b0, btn_pulse}, 32'h3);
    check_eq("press_e6_pend", {31'b0, any_pending}, 32'h1);
    tick();
    check_eq("press_e7_pulse", {28'b0, btn_pulse}, 32'h0);
    check_eq("press_e7_sticky", {28'b0, btn_sticky}, 32'h3);

    // Masked clear of bit 1 only.
    clr = 1'b1; clr_mask = 4'b0010;
    tick();
    clr = 1'b0; clr_mask = 4'hF;
    check_eq("clr_mask", {28'b0, btn_sticky}, 32'h1);
    tick();
    check_eq("clr_ignored", {28'b0, btn_sticky}, 32'h1);

    // Release of bit 1: falls at edge 6, no pulse, sticky untouched.
    btn_raw = 4'b0001;
    edges_until(1, 1'b0, n);
    check_eq("release_lat", n, 6);
    check_eq("release_pulse", {28'b0, btn_pulse}, 32'h0);
    check_eq("release_sticky", {28'b0, btn_sticky}, 32'h1);

    // Re-press bit 1 with clear of bit 1 on the very edge it is set.
    btn_raw = 4'b0011;
    for (int k = 1; k <= 5; k++) tick();
    clr = 1'b1; clr_mask = 4'b0011;
    tick();
    clr = 1'b0;
    check_eq("set_wins_pulse", {28'b0, btn_pulse}, 32'h2);
    check_eq("set_wins_sticky", {28'b0, btn_sticky}, 32'h2);

    // Glitch shorter than the window, then a full press takes full latency.
    btn_raw = 4'b0000;
    do_reset();
    btn_raw = 4'b0001;
    for (int k = 0; k < 3; k++) tick();
    btn_raw = 4'b0000;
    for (int k = 0; k < 8; k++) tick();
    check_eq("glitch_level", {28'b0, btn_level}, 32'h0);
    check_eq("glitch_sticky", {28'b0, btn_sticky}, 32'h0);
    btn_raw = 4'b0001;
    edges_until(0, 1'b1, n);
    check_eq("after_glitch_lat", n, 6);

    // Reset pulsed mid-count with the button held: async clear, then a new press.
    btn_raw = 4'b1000;
    do_reset();
    for (int k = 0; k < 3; k++) tick();
    reset = 1'b1;
    #1;
    model_clear();
    check_eq("async_rst", {20'b0, btn_level, btn_pulse, btn_sticky}, 32'h0);
    #2;
    reset = 1'b0;
    edges_until(3, 1'b1, n);
    check_eq("rst_mid_lat", n, 6);
    check_eq("rst_mid_pulse", {28'b0, btn_pulse}, 32'h8);
    check_eq("rst_mid_sticky", {28'b0, btn_sticky}, 32'h8);

    // Random bouncing buttons with random masked clears.
    btn_raw = 4'b0000;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 6) == 0) btn_raw[i] = ~btn_raw[i];
      clr      = ($urandom_range(0, 3) == 0);
      clr_mask = 4'($urandom_range(0, 15));
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
